// File: rtl/ssf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssf_pkg
// Description : Shared constants, FSM state type and reset map for the SSF
//               cartridge bank controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ssf_pkg;

    // Word offset (A3..A1) of each mapper register inside the /TIME window
    localparam logic [2:0] REG_SRAM  = 3'd0;
    localparam logic [2:0] REG_BANK1 = 3'd1;
    localparam logic [2:0] REG_BANK2 = 3'd2;
    localparam logic [2:0] REG_BANK3 = 3'd3;
    localparam logic [2:0] REG_BANK4 = 3'd4;
    localparam logic [2:0] REG_BANK5 = 3'd5;
    localparam logic [2:0] REG_BANK6 = 3'd6;
    localparam logic [2:0] REG_BANK7 = 3'd7;

    // A7..A4 pattern selecting $A130F1-$A130FF
    localparam logic [3:0] TIME_DECODE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_SETTLE_WAIT = 2'd1,
        ST_COMMIT      = 2'd2,
        ST_RELEASE     = 2'd3
    } wr_state_t;

    // Identity map: slot n points at bank n after reset
    function automatic logic [7:0] bank_reset_val(input logic [2:0] idx);
        return {5'd0, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ssf_bank_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ssf_bank_ctrl_if
// Description : Cartridge-edge bus and ROM/SRAM control bundle of the SSF
//               bank controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface ssf_bank_ctrl_if #(
    parameter int BANK_W = 8
);
    logic [22:0]       cart_addr;
    logic [7:0]        cart_data_lo;
    logic              time_n;
    logic              lwr_n;
    logic              ce0_n;
    logic              cas0_n;
    logic [BANK_W-1:0] rom_bank;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic              cfg_wr;

    modport master (
        output cart_addr, cart_data_lo, time_n, lwr_n, ce0_n, cas0_n,
        input  rom_bank, sram_ce_n, sram_oe_n, sram_we_n, cfg_wr
    );

    modport slave (
        input  cart_addr, cart_data_lo, time_n, lwr_n, ce0_n, cas0_n,
        output rom_bank, sram_ce_n, sram_oe_n, sram_we_n, cfg_wr
    );
endinterface
`default_nettype wire

// File: rtl/ssf_sync.sv
`default_nettype none
// ============================================================================
// Module      : ssf_sync
// Description : N-stage flop synchronizer with selectable reset level.
// Revision    : 1.0 - initial release
// ============================================================================
module ssf_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ssf_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ssf_bank_ctrl
// Description : Clocked SSF mapper: filters /TIME writes into the SRAM control
//               and bank registers and drives ROM bank / SRAM strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module ssf_bank_ctrl
    import ssf_pkg::*;
#(
    parameter int BANK_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    ssf_bank_ctrl_if.slave bus
);

    // Strobe order in the vector: {time_n, lwr_n, ce0_n, cas0_n}
    logic [3:0] w_strb_raw;
    logic [3:0] w_strb_sync;

    assign w_strb_raw = {bus.time_n, bus.lwr_n, bus.ce0_n, bus.cas0_n};

    for (genvar i = 0; i < 4; i++) begin : g_sync
        ssf_sync #(
            .STAGES  (SYNC_STAGES),
            .RST_VAL (1'b1)
        ) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (w_strb_raw[i]),
            .q     (w_strb_sync[i])
        );
    end

    logic w_time_s;
    logic w_lwr_s;
    logic w_ce0_s;
    logic w_cas0_s;

    assign w_time_s = w_strb_sync[3];
    assign w_lwr_s  = w_strb_sync[2];
    assign w_ce0_s  = w_strb_sync[1];
    assign w_cas0_s = w_strb_sync[0];

    logic [6:0] r_addr_lo;
    logic [2:0] r_slot;
    logic [7:0] r_data;
    logic       w_unused_addr;

    assign w_unused_addr = ^{bus.cart_addr[22:21], bus.cart_addr[17:7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_lo <= '0;
            r_slot    <= '0;
            r_data    <= '0;
        end else begin
            r_addr_lo <= bus.cart_addr[6:0];
            r_slot    <= bus.cart_addr[20:18];
            r_data    <= bus.cart_data_lo;
        end
    end

    wr_state_t         r_state;
    logic [3:0]        r_cnt;
    logic [6:0]        r_cap_addr;
    logic [7:0]        r_cap_data;
    logic              r_cfg_wr;
    logic [1:0]        r_sram_ctrl;
    logic [BANK_W-1:0] r_bank [1:7];

    logic              w_strobe_on;
    logic              w_hit;
    logic              w_same;
    logic [2:0]        w_idx;
    logic [BANK_W-1:0] w_wr_data;
    logic [4:0]        w_cnt_next;

    assign w_strobe_on = ~w_time_s & ~w_lwr_s;
    assign w_hit       = w_strobe_on && (r_addr_lo[6:3] == TIME_DECODE);
    assign w_same      = (r_addr_lo == r_cap_addr) && (r_data == r_cap_data);
    assign w_idx       = r_cap_addr[2:0];
    assign w_wr_data   = BANK_W'(r_cap_data);
    assign w_cnt_next  = {1'b0, r_cnt} + 5'd1;

    // Write sequencer: a commit needs a stable address/data under held strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_cap_addr  <= '0;
            r_cap_data  <= '0;
            r_cfg_wr    <= 1'b0;
            r_sram_ctrl <= 2'b00;
            for (int n = 1; n < 8; n++) begin
                r_bank[n] <= BANK_W'(bank_reset_val(3'(n)));
            end
        end else begin
            r_cfg_wr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        r_state    <= ST_SETTLE_WAIT;
                        r_cnt      <= 4'd1;
                        r_cap_addr <= r_addr_lo;
                        r_cap_data <= r_data;
                    end
                end
                ST_SETTLE_WAIT: begin
                    if (!w_strobe_on || !w_same) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_next[3:0];
                        if (w_cnt_next >= 5'(SETTLE)) begin
                            r_state  <= ST_COMMIT;
                            r_cfg_wr <= 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (w_idx == REG_SRAM) begin
                        r_sram_ctrl <= r_cap_data[1:0];
                    end else begin
                        r_bank[w_idx] <= w_wr_data;
                    end
                    r_state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (w_time_s || w_lwr_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Forward the committing value so a same-slot read sees it one cycle later
    logic [BANK_W-1:0] w_slot_val;
    logic              w_sram_sel;

    always_comb begin
        w_slot_val = '0;
        if (r_slot != 3'd0) begin
            if ((r_state == ST_COMMIT) && (w_idx == r_slot)) begin
                w_slot_val = w_wr_data;
            end else begin
                w_slot_val = r_bank[r_slot];
            end
        end
    end

    assign w_sram_sel = r_sram_ctrl[0] & ~w_ce0_s & r_slot[2];

    logic [BANK_W-1:0] r_rom_bank;
    logic              r_sram_ce_n;
    logic              r_sram_oe_n;
    logic              r_sram_we_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_bank  <= '0;
            r_sram_ce_n <= 1'b1;
            r_sram_oe_n <= 1'b1;
            r_sram_we_n <= 1'b1;
        end else begin
            r_rom_bank  <= w_slot_val;
            r_sram_ce_n <= ~w_sram_sel;
            r_sram_oe_n <= ~(w_sram_sel & ~w_cas0_s & w_lwr_s);
            r_sram_we_n <= ~(w_sram_sel & ~w_lwr_s & ~r_sram_ctrl[1]);
        end
    end

    assign bus.rom_bank  = r_rom_bank;
    assign bus.sram_ce_n = r_sram_ce_n;
    assign bus.sram_oe_n = r_sram_oe_n;
    assign bus.sram_we_n = r_sram_we_n;
    assign bus.cfg_wr    = r_cfg_wr;

endmodule
`default_nettype wire

// File: tb/tb_ssf_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssf_bank_ctrl
// Description : Directed self-checking bench for the SSF bank controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssf_bank_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   cfg_cnt;
    int   cfg_base;

    ssf_bank_ctrl_if #(.BANK_W(8)) bus ();

    ssf_bank_ctrl #(
        .BANK_W      (8),
        .SYNC_STAGES (2),
        .SETTLE      (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cfg_cnt = 0;
    always @(negedge clk) begin
        if (bus.cfg_wr === 1'b1) cfg_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [22:0] reg_addr(input logic [2:0] idx);
        return 23'h509878 | {20'd0, idx};
    endfunction

    function automatic logic [22:0] slot_addr(input logic [2:0] slot);
        return {2'b00, slot, 18'd0};
    endfunction

    task automatic bus_idle();
        bus.time_n = 1'b1;
        bus.lwr_n  = 1'b1;
        bus.ce0_n  = 1'b1;
        bus.cas0_n = 1'b1;
    endtask

    task automatic bus_write(input logic [2:0] idx, input logic [7:0] data,
                             input int hold, input int gap);
        @(posedge clk); #1;
        bus.cart_addr    = reg_addr(idx);
        bus.cart_data_lo = data;
        bus.time_n       = 1'b0;
        bus.lwr_n        = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        bus.time_n = 1'b1;
        bus.lwr_n  = 1'b1;
        repeat (gap) @(posedge clk);
    endtask

    task automatic check_slot(input string tag, input logic [2:0] slot, input logic [7:0] exp);
        @(posedge clk); #1;
        bus.cart_addr = slot_addr(slot);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(tag, {24'd0, bus.rom_bank}, {24'd0, exp});
    endtask

    task automatic sram_access(input logic a21, input logic ce0_n, input logic lwr_n,
                               input logic cas0_n);
        @(posedge clk); #1;
        bus.cart_addr = a21 ? 23'h100000 : 23'h000000;
        bus.ce0_n     = ce0_n;
        bus.lwr_n     = lwr_n;
        bus.cas0_n    = cas0_n;
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        bus.cart_addr    = '0;
        bus.cart_data_lo = '0;
        bus_idle();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rom_bank", {24'd0, bus.rom_bank}, 32'h0);
        check("rst_cfg_wr", {31'd0, bus.cfg_wr}, 32'h0);
        check("rst_sram_strobes", {29'd0, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}, 32'h7);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Reset asserted while a write sits in SETTLE_WAIT
        cfg_base = cfg_cnt;
        @(posedge clk); #1;
        bus.cart_addr    = reg_addr(3'd5);
        bus.cart_data_lo = 8'hAA;
        bus.time_n       = 1'b0;
        bus.lwr_n        = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        check("mid_write_reset_no_cfg", cfg_cnt - cfg_base, 0);
        check_slot("reset_slot5", 3'd5, 8'h05);
        check_slot("reset_slot1", 3'd1, 8'h01);
        check_slot("reset_slot7", 3'd7, 8'h07);
        check("reset_sram_ce_n", {31'd0, bus.sram_ce_n}, 32'h1);

        // Single write to bank 5
        cfg_base = cfg_cnt;
        bus_write(3'd5, 8'h2A, 6, 6);
        check("bank5_cfg_once", cfg_cnt - cfg_base, 1);
        check_slot("bank5_value", 3'd5, 8'h2A);
        check_slot("slot0_zero", 3'd0, 8'h00);

        // Strobe glitch of one cycle
        cfg_base = cfg_cnt;
        bus_write(3'd3, 8'h55, 1, 6);
        check("glitch_no_cfg", cfg_cnt - cfg_base, 0);
        check_slot("glitch_bank3", 3'd3, 8'h03);

        // Address leaves the /TIME window while in SETTLE_WAIT
        cfg_base = cfg_cnt;
        @(posedge clk); #1;
        bus.cart_addr    = reg_addr(3'd4);
        bus.cart_data_lo = 8'h77;
        bus.time_n       = 1'b0;
        bus.lwr_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.cart_addr = 23'h509804;
        repeat (5) @(posedge clk);
        #1;
        bus_idle();
        repeat (6) @(posedge clk);
        check("addr_change_no_cfg", cfg_cnt - cfg_base, 0);
        check_slot("addr_change_bank4", 3'd4, 8'h04);

        // SRAM enabled, writable
        cfg_base = cfg_cnt;
        bus_write(3'd0, 8'h01, 4, 6);
        check("sram_cfg_once", cfg_cnt - cfg_base, 1);
        check_slot("sram_write_keeps_bank1", 3'd1, 8'h01);
        sram_access(1'b1, 1'b0, 1'b0, 1'b1);
        check("sram_en_ce_n", {31'd0, bus.sram_ce_n}, 32'h0);
        check("sram_en_we_n", {31'd0, bus.sram_we_n}, 32'h0);
        check("sram_en_oe_n", {31'd0, bus.sram_oe_n}, 32'h1);
        sram_access(1'b0, 1'b0, 1'b0, 1'b1);
        check("sram_a21_low_ce_n", {31'd0, bus.sram_ce_n}, 32'h1);
        @(posedge clk); #1;
        bus_idle();
        repeat (4) @(posedge clk);

        // SRAM write-protected
        bus_write(3'd0, 8'h03, 4, 6);
        sram_access(1'b1, 1'b0, 1'b0, 1'b1);
        check("sram_wp_ce_n", {31'd0, bus.sram_ce_n}, 32'h0);
        check("sram_wp_we_n", {31'd0, bus.sram_we_n}, 32'h1);
        sram_access(1'b1, 1'b0, 1'b1, 1'b0);
        check("sram_wp_read_oe_n", {31'd0, bus.sram_oe_n}, 32'h0);
        check("sram_wp_read_we_n", {31'd0, bus.sram_we_n}, 32'h1);
        sram_access(1'b1, 1'b1, 1'b1, 1'b0);
        check("sram_ce0_high_ce_n", {31'd0, bus.sram_ce_n}, 32'h1);
        @(posedge clk); #1;
        bus_idle();
        repeat (4) @(posedge clk);

        // Back-to-back writes with a one-cycle strobe gap
        cfg_base = cfg_cnt;
        bus_write(3'd7, 8'hFF, 4, 1);
        bus_write(3'd1, 8'h10, 4, 6);
        check("b2b_cfg_twice", cfg_cnt - cfg_base, 2);
        check_slot("b2b_bank7", 3'd7, 8'hFF);
        check_slot("b2b_bank1", 3'd1, 8'h10);

        // Long strobe; the address/data change mid-strobe must be ignored
        cfg_base = cfg_cnt;
        @(posedge clk); #1;
        bus.cart_addr    = reg_addr(3'd2);
        bus.cart_data_lo = 8'h33;
        bus.time_n       = 1'b0;
        bus.lwr_n        = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        bus.cart_addr    = reg_addr(3'd6);
        bus.cart_data_lo = 8'h44;
        repeat (30) @(posedge clk);
        check("long_strobe_held_cfg_once", cfg_cnt - cfg_base, 1);
        #1;
        bus_idle();
        repeat (6) @(posedge clk);
        check("long_strobe_cfg_once", cfg_cnt - cfg_base, 1);
        check_slot("long_bank2", 3'd2, 8'h33);
        check_slot("long_bank6", 3'd6, 8'h06);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ssf_bank_ctrl.md
Name: ssf_bank_ctrl

Overview:
- Synchronous configuration controller for the SSF-style cartridge mapper.
- Captures console writes on the /TIME window ($A130F1-$A130FF) into one SRAM control register and seven 8-bit bank registers.
- Drives the upper ROM address bits and the SRAM chip controls from the current bank state.
- Sits between the cartridge edge connector and the ROM/SRAM address/enable pins; replaces the unclocked latch scheme with a clocked, glitch-filtered write sequencer.

Parameters:
- BANK_W, 8: bank register width; also the width of rom_bank.
- SYNC_STAGES, 2: synchronizer depth on time_n, lwr_n, ce0_n, cas0_n; legal values 2 or 3.
- SETTLE, 2: consecutive synced cycles a write strobe must be held before commit; range 1..15.

Ports:
- clk  in  1  controller clock, at least 4x the console bus strobe rate.
- rst_n  in  1  asynchronous, active-low reset.
- cart_addr  in  23  cartridge A23..A1, index 22 = A23.
- cart_data_lo  in  8  cartridge D7..D0.
- time_n  in  1  /TIME, low for $A130xx.
- lwr_n  in  1  lower-byte write strobe, active low.
- ce0_n  in  1  cartridge chip enable ($000000-$3FFFFF).
- cas0_n  in  1  read/write strobe for $000000-$DFFFFF.
- rom_bank  out  BANK_W  ROM address bits above A19 (512 KiB bank number).
- sram_ce_n  out  1  SRAM chip enable, active low.
- sram_oe_n  out  1  SRAM output enable, active low.
- sram_we_n  out  1  SRAM write enable, active low.
- cfg_wr  out  1  one-cycle pulse when a mapper register is committed.

Behaviour:
Input conditioning:
- time_n, lwr_n, ce0_n and cas0_n pass through SYNC_STAGES flops.
- cart_addr[6:0] and cart_data_lo are registered once per cycle alongside the synced strobes.

Write FSM (states IDLE, SETTLE_WAIT, COMMIT, RELEASE):
- IDLE -> SETTLE_WAIT when synced time_n=0, lwr_n=0 and A7..A4=4'b1111. The settle counter loads 1.
- SETTLE_WAIT: while the strobes stay low and the address/data match the values captured on entry, the counter increments. On reaching SETTLE, go to COMMIT.
- SETTLE_WAIT -> IDLE, with no write, if either strobe deasserts or the address/data change. This is a glitch reject.
- COMMIT (exactly 1 cycle): idx = A3..A1.
  - idx=0 writes sram_ctrl <= D1..D0 (bit0 = SRAM enable, bit1 = write protect).
  - idx=1..7 writes bank[idx] <= D[BANK_W-1:0].
  - cfg_wr=1 for this cycle. Go to RELEASE.
- RELEASE: wait until synced lwr_n=1 or time_n=1, then go to IDLE. This guarantees one commit per bus write regardless of strobe length.

Reset values (asynchronous on rst_n=0, any state):
- FSM=IDLE, cfg_wr=0.
- bank[n]=n for n=1..7 (identity map); sram_ctrl=2'b00.
- rom_bank=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1.
- Reset mid-write aborts with no partial commit.

Bank output:
- slot = A21..A19 (registered cart_addr).
- rom_bank = 0 when slot=0; otherwise bank[slot]. Zero-extend to BANK_W.
- Registered: 1 cycle after the address register.

SRAM select:
- sram_sel = sram_ctrl[0] & ~ce0_n(synced) & A21.
- sram_ce_n = ~sram_sel.
- sram_oe_n = ~(sram_sel & ~cas0_n & lwr_n).
- sram_we_n = ~(sram_sel & ~lwr_n & ~sram_ctrl[1]). Write-protect blocks writes; reads are unaffected.
- All three outputs are registered.

Boundary cases:
- Write to bank[0] address range (idx=0) never alters the bank map; slot 0 is permanently bank 0.
- A write while in RELEASE is ignored until the strobe releases.
- Data bits above BANK_W are ignored.
- When a COMMIT coincides with a ROM read of the same slot, the new bank value appears on rom_bank the cycle after COMMIT.

Decomposition:
- Package ssf_pkg:
  - Register word offset constants: REG_SRAM=0, REG_BANK1..7=1..7.
  - TIME decode constant 4'b1111.
  - FSM state enum.
  - Reset bank values.
- Sub-module ssf_sync: a parameterised N-stage synchronizer, instantiated per strobe.
- FSM, register file and output decode stay in ssf_bank_ctrl.

Test Plan:
- Reset: hold rst_n=0 mid-SETTLE_WAIT, release -> bank[1..7]=1..7, no cfg_wr pulse. Reading slot 5 gives rom_bank=5; sram_ce_n=1.
- Write $A130FB (A3..A1=5) with data 8'h2A, strobe held 6 clk -> exactly one cfg_wr. Subsequent access with A21..A19=5 gives rom_bank=8'h2A; slot 0 still gives 0.
- Glitch: lwr_n low for 1 synced cycle with SETTLE=2 -> no cfg_wr, bank unchanged. Address change during SETTLE_WAIT -> no commit.
- SRAM: write $A130F1 data 8'h01, then access A21=1 with ce0_n=0, lwr_n=0 -> sram_ce_n=0, sram_we_n=0. Write 8'h03, repeat -> sram_we_n=1; read with cas0_n=0 -> sram_oe_n=0.
- Back-to-back: write bank7=8'hFF, then bank1=8'h10 with 1 clk strobe gap -> two cfg_wr pulses. Slot 7 gives 8'hFF; slot 1 gives 8'h10.
- Long strobe: lwr_n low for 50 clk -> exactly one commit; FSM remains in RELEASE until lwr_n goes high.
